// File: rtl/dragster_line_reader.sv
// Line readout for the Dragster linear sensor: periodic start pulses, pixel capture into a FWFT FIFO, AXI4-Stream out.
// Optional macro DRAGSTER_LINE_READER_TEST_PATTERN_EN replaces pixel data with the pixel index.
module dragster_line_reader #(
  parameter int PIXELS_PER_LINE   = 1024,
  parameter int LINE_PERIOD       = 20000,
  parameter int START_PULSE_WIDTH = 4,
  parameter int DATA_WIDTH        = 8,
  parameter int FIFO_DEPTH        = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  config_done,
  output logic                  sensor_start,
  input  logic                  sensor_line_valid,
  input  logic                  sensor_pixel_valid,
  input  logic [DATA_WIDTH-1:0] sensor_pixel_data,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [1:0]            status,
  output logic [15:0]           line_count,
  output logic [2:0]            fsm_state
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = $clog2(LINE_PERIOD);
  localparam logic [PW-1:0] START_LAST  = PW'(START_PULSE_WIDTH - 1);
  localparam logic [PW-1:0] PERIOD_LAST = PW'(LINE_PERIOD - 1);
  localparam logic [PW-1:0] PERIOD_ONE  = PW'(1);
  localparam logic [15:0]   IDX_LAST    = 16'(PIXELS_PER_LINE - 1);
  localparam logic [AW:0]   PTR_ONE     = (AW + 1)'(1);

  typedef enum logic [2:0] {IDLE, START, WAIT_LINE, CAPTURE, GAP} state_t;

  state_t state, state_next;
  logic [PW-1:0] period_cnt;
  logic [15:0]   pix_idx;
  logic          enter_start, capture, line_done, short_line;

  logic [DATA_WIDTH:0] mem [FIFO_DEPTH];
  logic [AW:0]         wr_ptr, rd_ptr;
  logic                empty, full, rd_en, wr_en;
  logic [DATA_WIDTH-1:0] pixel_word;
  logic [DATA_WIDTH:0]   rd_word;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next  = state;
    enter_start = 1'b0;
    capture     = 1'b0;
    line_done   = 1'b0;
    short_line  = 1'b0;
    case (state)
      IDLE: begin
        if (enable && config_done) begin
          state_next  = START;
          enter_start = 1'b1;
        end
      end
      START: begin
        if (period_cnt == START_LAST) state_next = WAIT_LINE;
      end
      WAIT_LINE: begin
        if (sensor_line_valid) state_next = CAPTURE;
      end
      CAPTURE: begin
        if (!sensor_line_valid) begin
          short_line = 1'b1;
          state_next = GAP;
        end else if (sensor_pixel_valid) begin
          capture = 1'b1;
          if (pix_idx == IDX_LAST) begin
            line_done  = 1'b1;
            state_next = GAP;
          end
        end
      end
      GAP: begin
        // Counter saturates, so a late arrival in GAP restarts on the next cycle.
        if (period_cnt == PERIOD_LAST) begin
          if (enable) begin
            state_next  = START;
            enter_start = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      period_cnt <= '0;
      pix_idx    <= '0;
      line_count <= '0;
      status     <= '0;
    end else begin
      if (enter_start)                    period_cnt <= '0;
      else if (period_cnt != PERIOD_LAST) period_cnt <= period_cnt + PERIOD_ONE;
      if (state_next != CAPTURE) pix_idx <= '0;
      else if (capture)          pix_idx <= pix_idx + 16'd1;
      if (line_done) line_count <= line_count + 16'd1;
      if (capture && full && !rd_en) status[0] <= 1'b1;
      if (short_line)                status[1] <= 1'b1;
    end
  end

`ifdef DRAGSTER_LINE_READER_TEST_PATTERN_EN
  assign pixel_word = DATA_WIDTH'(pix_idx);
`else
  assign pixel_word = sensor_pixel_data;
`endif

  // A read in the same cycle frees a slot, so a write on a full FIFO is still accepted.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_en = !empty && m_axis_tready;
  assign wr_en = capture && (!full || rd_en);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_en) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= {line_done, pixel_word};
  end

  assign rd_word       = mem[rd_ptr[AW-1:0]];
  assign m_axis_tvalid = !empty;
  assign m_axis_tdata  = empty ? '0 : rd_word[DATA_WIDTH-1:0];
  assign m_axis_tlast  = empty ? 1'b0 : rd_word[DATA_WIDTH];
  assign sensor_start  = (state == START);
  assign fsm_state     = state;

endmodule

// File: tb/tb_dragster_line_reader.sv
// Self-checking bench for dragster_line_reader: scoreboard on the stream, start-pulse timing, status and reset.
// Expected pixel data follows DRAGSTER_LINE_READER_TEST_PATTERN_EN when that macro is defined.
module tb_dragster_line_reader;

  localparam int PPL = 8;
  localparam int LP  = 200;
  localparam int SPW = 4;
  localparam int DW  = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable, config_done;
  logic          sensor_start;
  logic          sensor_line_valid, sensor_pixel_valid;
  logic [DW-1:0] sensor_pixel_data;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic [1:0]    status;
  logic [15:0]   line_count;
  logic [2:0]    fsm_state;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_strobe_cyc = 0;
  int start_times[$];
  logic start_d = 1'b0;
  logic [DW:0] exp_q[$];

  dragster_line_reader #(
    .PIXELS_PER_LINE(PPL), .LINE_PERIOD(LP), .START_PULSE_WIDTH(SPW),
    .DATA_WIDTH(DW), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .config_done(config_done),
    .sensor_start(sensor_start), .sensor_line_valid(sensor_line_valid),
    .sensor_pixel_valid(sensor_pixel_valid), .sensor_pixel_data(sensor_pixel_data),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .status(status), .line_count(line_count), .fsm_state(fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish, cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  // monitor: start-rise timestamps and stream scoreboard
  always @(negedge clk) begin
    if (sensor_start && !start_d) start_times.push_back(cyc);
    start_d = sensor_start;
    if (!reset && m_axis_tvalid && m_axis_tready) begin
      if (exp_q.size() == 0) begin
        check("stream_extra", {23'd0, m_axis_tlast, m_axis_tdata}, 32'h1ff);
      end else begin
        check("stream_word", {23'd0, m_axis_tlast, m_axis_tdata}, {23'd0, exp_q.pop_front()});
      end
    end
  end

  // driver tasks
  task automatic wait_start(input int n_before, input int budget);
    int k = 0;
    while (start_times.size() == n_before && k < budget) begin
      @(posedge clk); #1; k++;
    end
    if (start_times.size() == n_before) check("start_timeout", 0, 1);
    k = 0;
    while (sensor_start && k < 20) begin
      @(posedge clk); #1; k++;
    end
  endtask

  task automatic drive_line(input int n_strobes, input int n_exp, input logic [DW-1:0] base,
                            input int min_gap, input int max_gap);
    logic [DW:0] w;
    @(posedge clk); #1;
    sensor_line_valid = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < n_strobes; i++) begin
      if (i > 0) repeat ($urandom_range(max_gap, min_gap)) begin @(posedge clk); #1; end
      sensor_pixel_valid = 1'b1;
      sensor_pixel_data  = base + DW'(i);
`ifdef DRAGSTER_LINE_READER_TEST_PATTERN_EN
      w[DW-1:0] = DW'(i);
`else
      w[DW-1:0] = base + DW'(i);
`endif
      w[DW] = (i == PPL - 1);
      if (i < n_exp) exp_q.push_back(w);
      last_strobe_cyc = cyc;
      @(posedge clk); #1;
      sensor_pixel_valid = 1'b0;
      sensor_pixel_data  = DW'($urandom_range(255, 0));
    end
    sensor_line_valid = 1'b0;
  endtask

  task automatic settle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    int n;
    reset = 1'b1; enable = 1'b0; config_done = 1'b0;
    sensor_line_valid = 1'b0; sensor_pixel_valid = 1'b0; sensor_pixel_data = '0;
    m_axis_tready = 1'b1;
    settle(3);
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_tdata", m_axis_tdata, 0);
    check("rst_tlast", m_axis_tlast, 0);
    check("rst_start", sensor_start, 0);
    check("rst_line_count", line_count, 0);
    check("rst_status", status, 0);
    check("rst_state", fsm_state, 0);

    // startup gating
    reset = 1'b0; enable = 1'b1;
    settle(100);
    check("gate_no_start", start_times.size(), 0);
    config_done = 1'b1;
    @(negedge clk) check("start_pre", sensor_start, 0);
    for (int i = 0; i < SPW; i++) @(negedge clk) check("start_hi", sensor_start, 1);
    @(negedge clk) check("start_lo", sensor_start, 0);

    // nominal line 0x10..0x17
    drive_line(PPL, PPL, 8'h10, 0, 0);
    settle(20);
    check("l1_drained", exp_q.size(), 0);
    check("l1_line_count", line_count, 1);
    check("l1_status", status, 0);

    // two more lines with random strobe gaps; period check
    wait_start(1, LP + 20);
    check("period_1", start_times[1] - start_times[0], LP);
    drive_line(PPL, PPL, 8'h20, 0, 2);
    settle(20);
    check("l2_line_count", line_count, 2);
    wait_start(2, LP + 20);
    check("period_2", start_times[2] - start_times[1], LP);
    drive_line(PPL, PPL, 8'h30, 0, 2);
    settle(20);
    check("l3_line_count", line_count, 3);

    // short line: 5 of 8
    wait_start(3, LP + 20);
    drive_line(5, 5, 8'h40, 0, 1);
    settle(20);
    check("short_drained", exp_q.size(), 0);
    check("short_status", status, 2'b10);
    check("short_line_count", line_count, 3);

    // overflow: tready low, 8 strobes into 4 entries
    wait_start(4, LP + 20);
    check("period_after_short", start_times[4] - start_times[3], LP);
    m_axis_tready = 1'b0;
    drive_line(PPL, 4, 8'h50, 0, 0);
    settle(3);
    check("ovf_status", status, 2'b11);
    check("ovf_line_count", line_count, 4);
    check("ovf_held_count", exp_q.size(), 4);
    check("ovf_hold_valid", m_axis_tvalid, 1);
    check("ovf_hold_data", m_axis_tdata, exp_q[0][DW-1:0]);
    m_axis_tready = 1'b1;
    settle(10);
    check("ovf_drained", exp_q.size(), 0);
    check("ovf_idle_valid", m_axis_tvalid, 0);

    // slow line longer than the period
    wait_start(5, LP + 20);
    check("period_after_ovf", start_times[5] - start_times[4], LP);
    drive_line(PPL, PPL, 8'h60, 35, 40);
    wait_start(6, 20);
    check("late_start", start_times[6] - last_strobe_cyc, 2);
    check("late_line_count", line_count, 5);

    // enable falls during the line: line completes, then IDLE
    enable = 1'b0;
    drive_line(PPL, PPL, 8'h70, 0, 2);
    settle(300);
    check("dis_no_start", start_times.size(), 7);
    check("dis_line_count", line_count, 6);
    check("dis_drained", exp_q.size(), 0);
    check("dis_status", status, 2'b11);

    // asynchronous reset in the middle of a line
    enable = 1'b1;
    n = start_times.size();
    wait_start(n, 20);
    m_axis_tready = 1'b0;
    @(posedge clk); #1; sensor_line_valid = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      sensor_pixel_valid = 1'b1;
      sensor_pixel_data  = DW'($urandom_range(255, 0));
      @(posedge clk); #1;
    end
    check("pre_reset_valid", m_axis_tvalid, 1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_tvalid", m_axis_tvalid, 0);
    check("mid_rst_start", sensor_start, 0);
    check("mid_rst_line_count", line_count, 0);
    check("mid_rst_status", status, 0);
    sensor_pixel_valid = 1'b0; sensor_line_valid = 1'b0; enable = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b0; m_axis_tready = 1'b1;
    settle(10);
    check("post_rst_tvalid", m_axis_tvalid, 0);
    check("post_rst_start", sensor_start, 0);
    check("final_queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dragster_line_reader.md
# dragster_line_reader

Downstream readout stage for the Dragster linear image sensor, fed by the SPI configurator. After `config_done` is asserted, the block issues periodic integration-start pulses to the sensor and captures each line of pixels from the sensor's parallel ADC bus. Pixels are buffered in a small FIFO and presented on an AXI4-Stream master, with `tlast` on the final pixel of each line. Sticky status flags report overflow and short lines.

## Interface
- `PIXELS_PER_LINE`, 1024: pixels captured per line; range 2..65535.
- `LINE_PERIOD`, 20000: clk cycles between consecutive `sensor_start` rising edges; must be > `START_PULSE_WIDTH`.
- `START_PULSE_WIDTH`, 4: `sensor_start` high time in clk cycles; minimum 1.
- `DATA_WIDTH`, 8: pixel width.
- `FIFO_DEPTH`, 16: buffer entries; power of two, minimum 4.

Ports:
- `clk` input 1: single clock for the whole block.
- `reset` input 1: asynchronous, active-high reset.
- `enable` input 1: run request.
- `config_done` input 1: sensor configuration finished; level signal.
- `sensor_start` output 1: integration/readout start pulse to the sensor.
- `sensor_line_valid` input 1: high while the sensor outputs a line.
- `sensor_pixel_valid` input 1: one-cycle strobe per pixel.
- `sensor_pixel_data` input DATA_WIDTH: pixel value, qualified by `sensor_pixel_valid`.
- `m_axis_tdata` output DATA_WIDTH: pixel out.
- `m_axis_tvalid` output 1: stream valid.
- `m_axis_tready` input 1: stream ready.
- `m_axis_tlast` output 1: last pixel of a line.
- `status` output 2: bit0 = overflow (sticky), bit1 = short line (sticky).
- `line_count` output 16: completed lines; wraps 0xFFFF→0.

## Operation
- **Reset values:** all outputs are 0, the FIFO is empty, the FSM is in IDLE, and all counters are 0.
- **IDLE:** leave when `enable && config_done`; go to START.
- **START:** drive `sensor_start` high for exactly `START_PULSE_WIDTH` cycles.
  - The period counter loads 0 on the first cycle of START and free-runs.
  - Go to WAIT_LINE.
- **WAIT_LINE:** wait for `sensor_line_valid` to be high; go to CAPTURE.
  - Any `sensor_pixel_valid` strobe seen here is ignored.
- **CAPTURE:** each strobe with `sensor_line_valid` high writes one pixel and increments the pixel index.
  - Index `PIXELS_PER_LINE-1` is written with the tlast bit set, then the FSM goes to GAP.
  - `line_count` increments on that cycle.
- **Short line:** `sensor_line_valid` falls before the final index is reached. Set `status[1]`, write no padding and no tlast, do not increment `line_count`, go to GAP.
- **Extra pixels:** after the final index, strobes are ignored until the next START.
- **GAP:** when the period counter reaches `LINE_PERIOD-1`, go to START if `enable`, otherwise go to IDLE.
  - If the period has already expired on entry to GAP (slow sensor), go to START on the next cycle.
- **Overflow:** a strobe arriving while the FIFO is full is dropped and sets `status[0]`.
  - The pixel index still advances, so tlast stays aligned to index `PIXELS_PER_LINE-1`.
  - If that final pixel is the one dropped, the line carries no tlast.
- **enable fall mid-line:** the current line completes; the block then returns to IDLE from GAP.
- **config_done fall:** ignored once the block has left IDLE.
- **FIFO:** first-word-fall-through, entries DATA_WIDTH+1 bits wide (data plus last).
  - A same-cycle write and read on a full FIFO is not an overflow, because the read frees the slot.
- **Status bits** clear only on `reset`.

## Timing
- `sensor_start` rises 1 cycle after the IDLE exit condition is sampled.
- Period from one `sensor_start` rise to the next is exactly `LINE_PERIOD` cycles while capture finishes in time.
- Pixel latency: a strobe at cycle N gives `m_axis_tvalid` at N+1 when the FIFO was empty.
- `tdata`, `tvalid` and `tlast` hold stable while `tvalid && !tready`.
- A transfer occurs on `tvalid && tready`; full throughput is 1 pixel/cycle.
- The stream keeps draining in every FSM state, including IDLE.
- `reset` asserted mid-line: outputs go to their reset values immediately (asynchronously) and buffered pixels are discarded.

## Configuration
- `DRAGSTER_LINE_READER_TEST_PATTERN_EN` defined: the value written to the FIFO is the pixel index truncated to DATA_WIDTH; `sensor_pixel_data` is ignored.
  - Strobe, line-valid, FSM and overflow behaviour are unchanged.
- Undefined: sensor data passes through unmodified, and no test-pattern logic is synthesized.

## Test plan
- **Startup gating:** `enable`=1 with `config_done`=0 for 100 cycles → `sensor_start` stays 0. Raise `config_done` → `sensor_start` high 4 cycles starting the next cycle.
- **Nominal line:** `PIXELS_PER_LINE`=8, `tready`=1, sensor sends 8 strobes with data 0x10..0x17 → stream carries 0x10..0x17, `tlast` only on 0x17, `line_count`=1, `status`=0.
- **Period:** `LINE_PERIOD`=200, three lines → `sensor_start` rises at cycles T, T+200 and T+400. A line lasting 250 cycles → next start 1 cycle after GAP is entered.
- **Overflow:** `FIFO_DEPTH`=4, `tready`=0, 8 strobes → 4 entries held, `status[0]`=1. Release `tready` → 4 pixels out with no `tlast`, `line_count`=1.
- **Short line:** `sensor_line_valid` falls after 5 of 8 pixels → 5 pixels out without `tlast`, `status[1]`=1, `line_count` unchanged, next start occurs at the period boundary.
- **Test pattern and reset:** with the macro defined, output is 0x00..0x07 regardless of input data. Assert `reset` at pixel 3 → `tvalid`=0, `sensor_start`=0, `line_count`=0 immediately.
